id_ex_stage: RTL and testbench

ID/EX pipeline stage register with load-use hazard detection for the 26-bit-instruction, 16-bit-PC pipelined processor. It sits between the decoder/register-bank read (ID) and the execute stage. It captures decoded fields, operands, sign-extended immediates and control bits each cycle, and inserts a bubble on a load-use dependency. It also back-pressures the PC and IF/ID register, and squashes its contents on a branch flush.

---
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch-flush squash and external hold. Counts inserted load-use bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_rn,
    input  logic [4:0]        id_rm,
    input  logic              id_uses_rn,
    input  logic              id_uses_rm,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [9:0]        id_imm10,
    input  logic [14:0]       id_imm15,
    input  logic [19:0]       id_imm20,
    input  logic [1:0]        id_imm_sel,
    input  logic [15:0]       id_pc,
    input  logic              id_we_rf,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [3:0]        id_alu_op,
    input  logic              flush,
    input  logic              stall_ext,
    output logic              ex_valid,
    output logic              ex_we_rf,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [5:0]        ex_opcode,
    output logic [3:0]        ex_alu_op,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_rn,
    output logic [4:0]        ex_rm,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [15:0]       ex_pc,
    output logic              pc_en,
    output logic              if_id_en,
    output logic [15:0]       bubble_count
);

    typedef struct packed {
        logic              valid;
        logic              we_rf;
        logic              mem_read;
        logic              mem_write;
        logic [5:0]        opcode;
        logic [3:0]        alu_op;
        logic [4:0]        rd;
        logic [4:0]        rn;
        logic [4:0]        rm;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
        logic [15:0]       pc;
    } ex_regs_t;

    ex_regs_t          r_ex;
    ex_regs_t          w_cap;
    logic [15:0]       r_bubble_count;
    logic [DATA_W-1:0] w_imm;
    logic              w_haz;
    logic              w_clear;
    logic              w_hold;
    logic              w_count;

    // A load in EX whose destination feeds the ID instruction; r0 never hazards.
    assign w_haz = r_ex.valid & r_ex.mem_read & (r_ex.rd != 5'd0) & id_valid &
                   ((id_uses_rn & (id_rn == r_ex.rd)) | (id_uses_rm & (id_rm == r_ex.rd)));

    // Enable contract: when pc_en/if_id_en are low the PC and IF/ID must keep
    // their contents; the ID instruction is then re-presented next cycle.
    assign pc_en    = ~(w_haz | stall_ext);
    assign if_id_en = ~(w_haz | stall_ext);

    // Priority: flush > stall_ext > hazard > capture.
    assign w_clear = flush | (~stall_ext & w_haz);
    assign w_hold  = ~flush & stall_ext;
    assign w_count = ~flush & ~stall_ext & w_haz;

    always_comb begin
        w_imm = '0;
        case (id_imm_sel)
            2'b01:   w_imm = {{(DATA_W-10){id_imm10[9]}}, id_imm10};
            2'b10:   w_imm = {{(DATA_W-15){id_imm15[14]}}, id_imm15};
            2'b11:   w_imm = {{(DATA_W-20){id_imm20[19]}}, id_imm20};
            default: w_imm = '0;
        endcase
    end

    always_comb begin
        w_cap           = '0;
        w_cap.valid     = id_valid;
        w_cap.we_rf     = id_valid & id_we_rf;
        w_cap.mem_read  = id_valid & id_mem_read;
        w_cap.mem_write = id_valid & id_mem_write;
        w_cap.opcode    = id_opcode;
        w_cap.alu_op    = id_alu_op;
        w_cap.rd        = id_rd;
        w_cap.rn        = id_rn;
        w_cap.rm        = id_rm;
        w_cap.a         = id_rd1;
        w_cap.b         = id_rd2;
        w_cap.imm       = w_imm;
        w_cap.pc        = id_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex <= '0;
        end else if (w_clear) begin
            r_ex <= '0;
        end else if (!w_hold) begin
            r_ex <= w_cap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_count <= '0;
        end else if (w_count && (r_bubble_count != 16'hFFFF)) begin
            r_bubble_count <= r_bubble_count + 16'd1;
        end
    end

    assign ex_valid     = r_ex.valid;
    assign ex_we_rf     = r_ex.we_rf;
    assign ex_mem_read  = r_ex.mem_read;
    assign ex_mem_write = r_ex.mem_write;
    assign ex_opcode    = r_ex.opcode;
    assign ex_alu_op    = r_ex.alu_op;
    assign ex_rd        = r_ex.rd;
    assign ex_rn        = r_ex.rn;
    assign ex_rm        = r_ex.rm;
    assign ex_a         = r_ex.a;
    assign ex_b         = r_ex.b;
    assign ex_imm       = r_ex.imm;
    assign ex_pc        = r_ex.pc;
    assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the stage's update rules.
module tb_id_ex_stage;
  localparam int W = 32;

  typedef struct packed {
    logic valid; logic we_rf; logic mem_read; logic mem_write;
    logic [5:0] opcode; logic [3:0] alu_op;
    logic [4:0] rd; logic [4:0] rn; logic [4:0] rm;
    logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] imm;
    logic [15:0] pc;
  } ex_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid, id_uses_rn, id_uses_rm, id_we_rf, id_mem_read, id_mem_write;
  logic [5:0] id_opcode;
  logic [4:0] id_rd, id_rn, id_rm;
  logic [W-1:0] id_rd1, id_rd2;
  logic [9:0] id_imm10;
  logic [14:0] id_imm15;
  logic [19:0] id_imm20;
  logic [1:0] id_imm_sel;
  logic [15:0] id_pc;
  logic [3:0] id_alu_op;
  logic flush, stall_ext;
  logic ex_valid, ex_we_rf, ex_mem_read, ex_mem_write;
  logic [5:0] ex_opcode;
  logic [3:0] ex_alu_op;
  logic [4:0] ex_rd, ex_rn, ex_rm;
  logic [W-1:0] ex_a, ex_b, ex_imm;
  logic [15:0] ex_pc;
  logic pc_en, if_id_en;
  logic [15:0] bubble_count;

  int n_vec = 0;
  int n_err = 0;
  ex_t m_ex;
  logic [15:0] m_cnt;

  // clock/reset block
  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm10(id_imm10), .id_imm15(id_imm15), .id_imm20(id_imm20),
    .id_imm_sel(id_imm_sel), .id_pc(id_pc), .id_we_rf(id_we_rf),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
    .flush(flush), .stall_ext(stall_ext),
    .ex_valid(ex_valid), .ex_we_rf(ex_we_rf), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_opcode(ex_opcode), .ex_alu_op(ex_alu_op),
    .ex_rd(ex_rd), .ex_rn(ex_rn), .ex_rm(ex_rm),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc),
    .pc_en(pc_en), .if_id_en(if_id_en), .bubble_count(bubble_count)
  );

  function automatic ex_t dut_state();
    return {ex_valid, ex_we_rf, ex_mem_read, ex_mem_write, ex_opcode, ex_alu_op,
            ex_rd, ex_rn, ex_rm, ex_a, ex_b, ex_imm, ex_pc};
  endfunction

  // reference model: what EX should hold if the current ID is captured
  function automatic ex_t model_capture();
    ex_t e;
    logic [31:0] imm;
    case (id_imm_sel)
      2'd1: begin imm = 32'(id_imm10); if (imm >= 32'd512)    imm = imm - 32'd1024;    end
      2'd2: begin imm = 32'(id_imm15); if (imm >= 32'd16384)  imm = imm - 32'd32768;   end
      2'd3: begin imm = 32'(id_imm20); if (imm >= 32'd524288) imm = imm - 32'd1048576; end
      default: imm = 32'd0;
    endcase
    e.valid = id_valid;
    e.we_rf = id_valid && id_we_rf;
    e.mem_read = id_valid && id_mem_read;
    e.mem_write = id_valid && id_mem_write;
    e.opcode = id_opcode; e.alu_op = id_alu_op;
    e.rd = id_rd; e.rn = id_rn; e.rm = id_rm;
    e.a = id_rd1; e.b = id_rd2; e.imm = imm; e.pc = id_pc;
    return e;
  endfunction

  function automatic bit model_haz();
    if (!(m_ex.valid && m_ex.mem_read && m_ex.rd != 0 && id_valid)) return 1'b0;
    return (id_uses_rn && id_rn == m_ex.rd) || (id_uses_rm && id_rm == m_ex.rd);
  endfunction

  // advance one clock and step the model; inputs only change at negedge
  task automatic tick();
    bit h;
    h = model_haz();
    @(posedge clk);
    if (flush) m_ex = '0;
    else if (stall_ext) m_ex = m_ex;
    else if (h) begin
      m_ex = '0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else m_ex = model_capture();
    @(negedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive_random_id(input int reg_max);
    id_valid = ($urandom_range(0, 7) != 0);
    id_opcode = 6'($urandom); id_alu_op = 4'($urandom);
    id_rd = 5'($urandom_range(0, reg_max)); id_rn = 5'($urandom_range(0, reg_max));
    id_rm = 5'($urandom_range(0, reg_max));
    id_uses_rn = 1'($urandom); id_uses_rm = 1'($urandom);
    id_rd1 = $urandom; id_rd2 = $urandom;
    id_imm10 = 10'($urandom); id_imm15 = 15'($urandom); id_imm20 = 20'($urandom);
    id_imm_sel = 2'($urandom); id_pc = 16'($urandom);
    id_we_rf = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic is_load);
    drive_random_id(31);
    id_valid = 1; id_rd = rd; id_mem_read = is_load; id_we_rf = 1;
    id_uses_rn = 0; id_uses_rm = 0;
  endtask

  task automatic drive_dependent(input logic [4:0] src, input logic uses);
    drive_random_id(31);
    id_valid = 1; id_rd = 5'd7; id_rn = src; id_uses_rn = uses;
    id_rm = 5'd9; id_uses_rm = 0; id_mem_read = 0;
  endtask

  task automatic test_reset();
    drive_random_id(31);
    flush = 0; stall_ext = 0; rst = 1;
    m_ex = '0; m_cnt = 0;
    @(negedge clk); #1;
    n_vec++;
    if (dut_state() !== ex_t'(0) || bubble_count !== 16'h0) begin
      n_err++; $display("FAIL reset_state: got %h cnt %h, want 0", dut_state(), bubble_count);
    end
    n_vec++;
    if (pc_en !== 1'b1 || if_id_en !== 1'b1) begin
      n_err++; $display("FAIL reset_enables: pc_en %b if_id_en %b, want 1", pc_en, if_id_en);
    end
    rst = 0;
  endtask

  task automatic test_capture();
    drive_random_id(31);
    id_valid = 1; id_rd = 5'd3; id_rd1 = 32'h12345678; id_pc = 16'h0010;
    id_imm_sel = 2'b01; id_imm10 = 10'h200; id_uses_rn = 0; id_uses_rm = 0;
    tick();
    n_vec++;
    if (ex_rd !== 5'd3 || ex_a !== 32'h12345678 || ex_pc !== 16'h0010 || ex_imm !== 32'hFFFFFE00) begin
      n_err++; $display("FAIL capture: rd %0d a %h pc %h imm %h, want 3 12345678 0010 fffffe00",
                        ex_rd, ex_a, ex_pc, ex_imm);
    end
    n_vec++;
    if (dut_state() !== m_ex) begin
      n_err++; $display("FAIL capture_all: got %h want %h", dut_state(), m_ex);
    end
  endtask

  task automatic test_load_use();
    logic [15:0] c0;
    drive_load(5'd5, 1'b1);
    tick();
    c0 = bubble_count;
    drive_dependent(5'd5, 1'b1);
    #1;
    n_vec++;
    if (pc_en !== 1'b0 || if_id_en !== 1'b0) begin
      n_err++; $display("FAIL load_use_stall: pc_en %b if_id_en %b, want 0", pc_en, if_id_en);
    end
    tick();
    n_vec++;
    if (ex_valid !== 1'b0 || bubble_count !== c0 + 16'd1) begin
      n_err++; $display("FAIL load_use_bubble: valid %b cnt %h, want 0 %h", ex_valid, bubble_count, c0 + 16'd1);
    end
    n_vec++;
    if (pc_en !== 1'b1) begin
      n_err++; $display("FAIL load_use_release: pc_en %b, want 1", pc_en);
    end
    tick();
    n_vec++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || dut_state() !== m_ex) begin
      n_err++; $display("FAIL load_use_capture: got %h want %h", dut_state(), m_ex);
    end
  endtask

  task automatic test_no_false_hazard();
    logic [15:0] c0;
    for (int v = 0; v < 3; v++) begin
      drive_load(v == 0 ? 5'd0 : 5'd5, v != 1);
      tick();
      c0 = bubble_count;
      drive_dependent(v == 0 ? 5'd0 : 5'd5, v != 2);
      #1;
      n_vec++;
      if (pc_en !== 1'b1 || if_id_en !== 1'b1) begin
        n_err++; $display("FAIL no_haz_en[%0d]: pc_en %b if_id_en %b, want 1", v, pc_en, if_id_en);
      end
      tick();
      n_vec++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || bubble_count !== c0) begin
        n_err++; $display("FAIL no_haz_cap[%0d]: valid %b rd %0d cnt %h, want 1 7 %h",
                          v, ex_valid, ex_rd, bubble_count, c0);
      end
    end
  endtask

  task automatic test_flush_priority();
    logic [15:0] c0;
    drive_load(5'd5, 1'b1);
    tick();
    c0 = bubble_count;
    drive_dependent(5'd5, 1'b1);
    flush = 1; stall_ext = 1;
    #1;
    n_vec++;
    if (pc_en !== 1'b0) begin
      n_err++; $display("FAIL flush_pc_en: pc_en %b, want 0", pc_en);
    end
    tick();
    flush = 0; stall_ext = 0;
    n_vec++;
    if (ex_valid !== 1'b0 || ex_we_rf !== 1'b0 || bubble_count !== c0 || dut_state() !== ex_t'(0)) begin
      n_err++; $display("FAIL flush: valid %b we %b cnt %h, want 0 0 %h", ex_valid, ex_we_rf, bubble_count, c0);
    end
  endtask

  task automatic test_ext_stall();
    ex_t held;
    drive_load(5'd12, 1'b0);
    tick();
    held = dut_state();
    stall_ext = 1;
    for (int i = 0; i < 3; i++) begin
      drive_random_id(31);
      #1;
      n_vec++;
      if (pc_en !== 1'b0 || if_id_en !== 1'b0) begin
        n_err++; $display("FAIL stall_en[%0d]: pc_en %b if_id_en %b, want 0", i, pc_en, if_id_en);
      end
      tick();
      n_vec++;
      if (dut_state() !== held || dut_state() !== m_ex) begin
        n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", i, dut_state(), m_ex);
      end
    end
    stall_ext = 0;
    drive_random_id(31);
    id_uses_rn = 0; id_uses_rm = 0;
    tick();
    n_vec++;
    if (dut_state() !== model_capture() || dut_state() !== m_ex) begin
      n_err++; $display("FAIL stall_resume: got %h want %h", dut_state(), m_ex);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_random_id(3);
      flush = ($urandom_range(0, 15) == 0);
      stall_ext = ($urandom_range(0, 7) == 0);
      #1;
      n_vec++;
      if (pc_en !== !(model_haz() || stall_ext) || if_id_en !== pc_en) begin
        n_err++; $display("FAIL rand_en[%0d]: pc_en %b if_id_en %b, want %b",
                          i, pc_en, if_id_en, !(model_haz() || stall_ext));
      end
      tick();
      n_vec++;
      if (dut_state() !== m_ex || bubble_count !== m_cnt) begin
        n_err++; $display("FAIL rand_state[%0d]: got %h cnt %h want %h cnt %h",
                          i, dut_state(), bubble_count, m_ex, m_cnt);
      end
    end
    flush = 0; stall_ext = 0;
  endtask

  task automatic test_saturation_reset();
    force dut.r_bubble_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      drive_load(5'd6, 1'b1);
      tick();
      drive_dependent(5'd6, 1'b1);
      tick();
      if (k == 0) release dut.r_bubble_count;
    end
    n_vec++;
    if (bubble_count !== 16'hFFFF || bubble_count !== m_cnt || ex_valid !== 1'b0) begin
      n_err++; $display("FAIL saturate: cnt %h valid %b, want ffff 0", bubble_count, ex_valid);
    end
    drive_load(5'd6, 1'b1);
    tick();
    #2 rst = 1;
    #1;
    n_vec++;
    if (dut_state() !== ex_t'(0) || bubble_count !== 16'h0) begin
      n_err++; $display("FAIL async_reset: got %h cnt %h, want 0", dut_state(), bubble_count);
    end
    n_vec++;
    if (pc_en !== 1'b1 || if_id_en !== 1'b1) begin
      n_err++; $display("FAIL async_reset_en: pc_en %b if_id_en %b, want 1", pc_en, if_id_en);
    end
    @(negedge clk);
    rst = 0;
    m_ex = '0; m_cnt = 0;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_no_false_hazard();
    test_flush_priority();
    test_ext_stall();
    test_random();
    test_saturation_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1, "timeout");
  end
endmodule
